// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester port identifiers and a small decode helper.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    function automatic logic [1:0] port_onehot(input logic id);
        return (id == PORT_LDR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two request ports, the response signals and the data_memory side
// of the arbiter; slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
        output mem_address, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
        input  mem_address, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way combinational arbiter: single requester always wins; on a tie either
// port 0 wins (fixed priority) or the port that was not granted last wins.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_fixed_prio,
    output logic [1:0] o_grant
);

    // One-hot grant selection
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
            2'b11: begin
                if (i_fixed_prio || (i_last_grant == PORT_LDR)) begin
                    o_grant = 2'b01;
                end else begin
                    o_grant = 2'b10;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (port 0) and the
// loader/debug port (port 1): accept, one-cycle memory strobe, one-cycle response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    dmem_arbiter_if.slave io_bus
);

    state_e            r_state;
    state_e            w_next_state;
    logic              r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_last_grant;
    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic [1:0]        w_accept;
    logic              w_accept_id;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [1:0]        w_rsp;

    assign w_valid     = {io_bus.req1_valid, io_bus.req0_valid};
    assign w_accept_id = w_accept[1];

    rr_arbiter2 u_arb (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .i_fixed_prio (FIXED_PRIO),
        .o_grant      (w_grant)
    );

    // Next-state and accept decode; requests are only taken in IDLE and never under reset
    always_comb begin
        w_next_state = r_state;
        w_accept     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (!i_rst) begin
                    w_accept = w_grant;
                end else begin
                    w_accept = 2'b00;
                end
                if (|w_accept) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Memory strobes and response pulse, all forced low while reset is held
    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_rsp       = 2'b00;
        if (!i_rst && (r_state == ST_ACCESS)) begin
            w_mem_read  = !r_we;
            w_mem_write = r_we;
        end else begin
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
        end
        if (!i_rst && (r_state == ST_RESP)) begin
            w_rsp = port_onehot(r_id);
        end else begin
            w_rsp = 2'b00;
        end
    end

    // State, request latch, arbitration history and load-data register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_id         <= PORT_CPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_last_grant <= PORT_LDR;
        end else begin
            r_state <= w_next_state;
            if (|w_accept) begin
                r_id         <= w_accept_id;
                r_we         <= w_accept_id ? io_bus.req1_we    : io_bus.req0_we;
                r_addr       <= w_accept_id ? io_bus.req1_addr  : io_bus.req0_addr;
                r_wdata      <= w_accept_id ? io_bus.req1_wdata : io_bus.req0_wdata;
                r_last_grant <= w_accept_id;
            end
            if ((r_state == ST_ACCESS) && !r_we) begin
                r_rdata <= io_bus.mem_rdata;
            end
        end
    end

    assign io_bus.req0_ready  = w_accept[0];
    assign io_bus.req1_ready  = w_accept[1];
    assign io_bus.rsp0_valid  = w_rsp[0];
    assign io_bus.rsp1_valid  = w_rsp[1];
    assign io_bus.rsp_rdata   = r_rdata;
    assign io_bus.mem_address = r_addr;
    assign io_bus.mem_wdata   = r_wdata;
    assign io_bus.mem_read    = w_mem_read;
    assign io_bus.mem_write   = w_mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (lane 0) and a fixed-priority
// instance (lane 1), each with its own memory, checked every cycle against a timeline model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus_rr ();
    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus_fx ();

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRIO(1'b0)) dut_rr (
        .i_clk(clk), .i_rst(rst), .io_bus(bus_rr.slave));
    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRIO(1'b1)) dut_fx (
        .i_clk(clk), .i_rst(rst), .io_bus(bus_fx.slave));

    // stimulus per [lane][port]
    logic        d_valid [2][2];
    logic        d_we    [2][2];
    logic [63:0] d_addr  [2][2];
    logic [63:0] d_wdata [2][2];

    assign bus_rr.req0_valid = d_valid[0][0];
    assign bus_rr.req0_we    = d_we[0][0];
    assign bus_rr.req0_addr  = d_addr[0][0];
    assign bus_rr.req0_wdata = d_wdata[0][0];
    assign bus_rr.req1_valid = d_valid[0][1];
    assign bus_rr.req1_we    = d_we[0][1];
    assign bus_rr.req1_addr  = d_addr[0][1];
    assign bus_rr.req1_wdata = d_wdata[0][1];
    assign bus_fx.req0_valid = d_valid[1][0];
    assign bus_fx.req0_we    = d_we[1][0];
    assign bus_fx.req0_addr  = d_addr[1][0];
    assign bus_fx.req0_wdata = d_wdata[1][0];
    assign bus_fx.req1_valid = d_valid[1][1];
    assign bus_fx.req1_we    = d_we[1][1];
    assign bus_fx.req1_addr  = d_addr[1][1];
    assign bus_fx.req1_wdata = d_wdata[1][1];

    logic [1:0]  o_ready [2];
    logic [1:0]  o_rsp   [2];
    logic [63:0] o_rdata [2];
    logic [63:0] o_maddr [2];
    logic [63:0] o_mwdata[2];
    logic        o_mrd   [2];
    logic        o_mwr   [2];

    assign o_ready[0]  = {bus_rr.req1_ready, bus_rr.req0_ready};
    assign o_ready[1]  = {bus_fx.req1_ready, bus_fx.req0_ready};
    assign o_rsp[0]    = {bus_rr.rsp1_valid, bus_rr.rsp0_valid};
    assign o_rsp[1]    = {bus_fx.rsp1_valid, bus_fx.rsp0_valid};
    assign o_rdata[0]  = bus_rr.rsp_rdata;
    assign o_rdata[1]  = bus_fx.rsp_rdata;
    assign o_maddr[0]  = bus_rr.mem_address;
    assign o_maddr[1]  = bus_fx.mem_address;
    assign o_mwdata[0] = bus_rr.mem_wdata;
    assign o_mwdata[1] = bus_fx.mem_wdata;
    assign o_mrd[0]    = bus_rr.mem_read;
    assign o_mrd[1]    = bus_fx.mem_read;
    assign o_mwr[0]    = bus_rr.mem_write;
    assign o_mwr[1]    = bus_fx.mem_write;

    // data_memory stand-ins: combinational read, clocked write
    logic [63:0] env_mem0 [1024];
    logic [63:0] env_mem1 [1024];
    logic        env_first = 1'b1;
    assign bus_rr.mem_rdata = env_mem0[bus_rr.mem_address[9:0]];
    assign bus_fx.mem_rdata = env_mem1[bus_fx.mem_address[9:0]];

    always @(posedge clk) begin
        if (env_first) begin
            for (int i = 0; i < 1024; i++) begin
                env_mem0[i] <= 64'd0;
                env_mem1[i] <= 64'd0;
            end
            env_first <= 1'b0;
        end else begin
            if (bus_rr.mem_write) env_mem0[bus_rr.mem_address[9:0]] <= bus_rr.mem_wdata;
            if (bus_fx.mem_write) env_mem1[bus_fx.mem_address[9:0]] <= bus_fx.mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: each access is a timeline (accept T, strobe T+1, response T+2, free T+3)
    int          cyc = 0;
    int          free_at [2] = '{0, 0};
    int          acc_at  [2] = '{-100, -100};
    logic        t_id    [2];
    logic        t_we    [2];
    logic [63:0] t_addr  [2];
    logic [63:0] t_wdata [2];
    logic        last_g  [2];
    logic [63:0] rdata_exp [2];
    logic [63:0] gold [2][1024];
    int          acc_port_q [2][$];
    int          acc_cyc_q  [2][$];

    always @(negedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) begin
                gold[0][i] = 64'd0;
                gold[1][i] = 64'd0;
            end
        end
        for (int l = 0; l < 2; l++) begin : lane_chk
            logic [1:0] eg;
            logic       erd;
            logic       ewr;
            logic [1:0] ersp;
            logic       id;
            eg = 2'b00; erd = 1'b0; ewr = 1'b0; ersp = 2'b00;
            if (!rst) begin
                if (cyc >= free_at[l]) begin
                    if (d_valid[l][0] && d_valid[l][1]) begin
                        // lane 1 is fixed priority; lane 0 favours the port not served last
                        eg = (l == 1 || last_g[l] == 1'b1) ? 2'b01 : 2'b10;
                    end else begin
                        eg = {d_valid[l][1], d_valid[l][0]};
                    end
                end
                if (cyc == acc_at[l] + 1) begin
                    erd = !t_we[l];
                    ewr = t_we[l];
                end
                if (cyc == acc_at[l] + 2) ersp = t_id[l] ? 2'b10 : 2'b01;
            end
            chk($sformatf("L%0d ready", l), 64'(o_ready[l]), 64'(eg));
            chk($sformatf("L%0d mem_read", l), 64'(o_mrd[l]), 64'(erd));
            chk($sformatf("L%0d mem_write", l), 64'(o_mwr[l]), 64'(ewr));
            chk($sformatf("L%0d rsp_valid", l), 64'(o_rsp[l]), 64'(ersp));
            if (!rst) chk($sformatf("L%0d rsp_rdata", l), o_rdata[l], rdata_exp[l]);
            if (!rst && cyc == acc_at[l] + 1) begin
                chk($sformatf("L%0d mem_address", l), o_maddr[l], t_addr[l]);
                if (t_we[l]) chk($sformatf("L%0d mem_wdata", l), o_mwdata[l], t_wdata[l]);
            end
            if (rst) begin
                acc_at[l]    = -100;
                free_at[l]   = cyc + 1;
                last_g[l]    = 1'b1;
                rdata_exp[l] = 64'd0;
            end else begin
                if (cyc == acc_at[l] + 1) begin
                    if (t_we[l]) gold[l][t_addr[l][9:0]] = t_wdata[l];
                    else rdata_exp[l] = gold[l][t_addr[l][9:0]];
                end
                if (eg != 2'b00) begin
                    id         = eg[1];
                    t_id[l]    = id;
                    t_we[l]    = d_we[l][id];
                    t_addr[l]  = d_addr[l][id];
                    t_wdata[l] = d_wdata[l][id];
                    acc_at[l]  = cyc;
                    free_at[l] = cyc + 3;
                    last_g[l]  = id;
                    acc_port_q[l].push_back(int'(id));
                    acc_cyc_q[l].push_back(cyc);
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int l, input int p, input logic we,
                          input logic [63:0] a, input logic [63:0] w);
        bit got;
        got = 1'b0;
        d_valid[l][p] = 1'b1;
        d_we[l][p]    = we;
        d_addr[l][p]  = a;
        d_wdata[l][p] = w;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (o_ready[l][p]) got = 1'b1;
        end
        if (!got) chk("accept timeout", 64'd0, 64'd1);
        tick();
        d_valid[l][p] = 1'b0;
    endtask

    int obs_port [2][$];
    int obs_cyc  [2][$];
    bit saw_r1   [2];

    task automatic run_obs(input int n);
        for (int l = 0; l < 2; l++) begin
            obs_port[l].delete();
            obs_cyc[l].delete();
            acc_port_q[l].delete();
            acc_cyc_q[l].delete();
            saw_r1[l] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (o_ready[l] != 2'b00) begin
                    obs_port[l].push_back(int'(o_ready[l][1]));
                    obs_cyc[l].push_back(i);
                end
                if (o_ready[l][1]) saw_r1[l] = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        logic        smp [2][2];
        logic [63:0] a;
        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 2; p++) begin
                d_valid[l][p] = 1'b0;
                d_we[l][p]    = 1'b0;
                d_addr[l][p]  = 64'd0;
                d_wdata[l][p] = 64'd0;
            end
        end
        d_valid[0][0] = 1'b1;

        // reset held two cycles with a pending request
        repeat (2) begin
            @(negedge clk);
            chk("rst ready0", 64'(o_ready[0][0]), 64'd0);
            chk("rst rsp", 64'(o_rsp[0]), 64'd0);
            chk("rst strobe", 64'({o_mrd[0], o_mwr[0]}), 64'd0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready after rst", 64'(o_ready[0][0]), 64'd1);
        tick();
        d_valid[0][0] = 1'b0;
        repeat (4) tick();

        // store then load at address 5
        do_req(0, 0, 1'b1, 64'd5, 64'hDEADBEEF);
        @(negedge clk);
        chk("store mem_write T+1", 64'(o_mwr[0]), 64'd1);
        chk("store mem_address", o_maddr[0], 64'd5);
        tick();
        @(negedge clk);
        chk("store rsp0 T+2", 64'(o_rsp[0]), 64'd1);
        tick();
        do_req(0, 0, 1'b0, 64'd5, 64'd0);
        @(negedge clk);
        chk("load mem_read T+1", 64'(o_mrd[0]), 64'd1);
        tick();
        @(negedge clk);
        chk("load rsp0 T+2", 64'(o_rsp[0]), 64'd1);
        chk("load rdata", o_rdata[0], 64'hDEADBEEF);
        tick();

        // contention on both lanes right after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 2; p++) begin
                d_valid[l][p] = 1'b1;
                d_we[l][p]    = 1'b0;
                d_addr[l][p]  = 64'(16 + p);
            end
        end
        run_obs(12);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 2; p++) d_valid[l][p] = 1'b0;
        end
        chk("rr grant count", 64'(obs_port[0].size()), 64'd4);
        chk("fx grant count", 64'(obs_port[1].size()), 64'd4);
        chk("rr model count", 64'(acc_port_q[0].size()), 64'd4);
        if (obs_port[0].size() == 4 && acc_port_q[0].size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr grant %0d", i), 64'(obs_port[0][i]), 64'(i % 2));
                chk($sformatf("rr model grant %0d", i), 64'(acc_port_q[0][i]), 64'(i % 2));
                chk($sformatf("rr accept cycle %0d", i), 64'(obs_cyc[0][i]), 64'(3 * i));
            end
        end
        if (obs_port[1].size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("fx grant %0d", i), 64'(obs_port[1][i]), 64'd0);
        end
        chk("fx req1_ready never", 64'(saw_r1[1]), 64'd0);
        repeat (3) tick();

        // reset during the ACCESS cycle of a load from address 7
        do_req(0, 0, 1'b1, 64'd7, 64'h1234);
        repeat (2) tick();
        do_req(0, 0, 1'b0, 64'd7, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst mem_read", 64'(o_mrd[0]), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst no rsp", 64'(o_rsp[0]), 64'd0);
        chk("midrst rdata", o_rdata[0], 64'd0);
        tick();
        do_req(0, 0, 1'b0, 64'd7, 64'd0);
        tick();
        @(negedge clk);
        chk("reload addr7", o_rdata[0], 64'h1234);
        tick();

        // lone loader requester keeps being served every 3 cycles
        d_valid[0][1] = 1'b1;
        d_we[0][1]    = 1'b0;
        d_addr[0][1]  = 64'd9;
        run_obs(9);
        d_valid[0][1] = 1'b0;
        chk("single count", 64'(obs_port[0].size()), 64'd3);
        if (obs_port[0].size() >= 2) begin
            chk("single port a", 64'(obs_port[0][0]), 64'd1);
            chk("single port b", 64'(obs_port[0][1]), 64'd1);
            chk("single gap", 64'(obs_cyc[0][1] - obs_cyc[0][0]), 64'd3);
        end
        repeat (3) tick();

        // randomized traffic with occasional resets and abandoned requests
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                for (int p = 0; p < 2; p++) smp[l][p] = o_ready[l][p];
            end
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            for (int l = 0; l < 2; l++) begin
                for (int p = 0; p < 2; p++) begin
                    bit fresh;
                    fresh = 1'b0;
                    if (d_valid[l][p] && smp[l][p]) begin
                        if ($urandom_range(0, 1) == 0) fresh = 1'b1;
                        else d_valid[l][p] = 1'b0;
                    end else if (d_valid[l][p]) begin
                        if ($urandom_range(0, 15) == 0) d_valid[l][p] = 1'b0;
                    end else if ($urandom_range(0, 4) < 2) begin
                        fresh = 1'b1;
                    end
                    if (fresh) begin
                        a = {$urandom(), $urandom()};
                        a[9:0] = 10'($urandom_range(0, 15));
                        d_valid[l][p] = 1'b1;
                        d_we[l][p]    = 1'($urandom_range(0, 1));
                        d_addr[l][p]  = a;
                        d_wdata[l][p] = {$urandom(), $urandom()};
                    end
                end
            end
        end
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 2; p++) d_valid[l][p] = 1'b0;
        end
        rst = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
